hangman_ctrl_p: RTL and testbench
=================================

HANGMAN_CTRL_P -- requirements
Module: hangman_ctrl_p

Interface
REQ-001 SHALL provide parameter WORD_LEN, default 5, number of letters per word.
REQ-002 SHALL provide parameter CHAR_W, default 5, bits per letter code.
REQ-003 SHALL provide parameter MAX_TRIES, default 7, wrong guesses allowed before loss.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request a new game.
REQ-007 SHALL have port word, input, WORD_LEN*CHAR_W, secret word; letter i occupies bits [(i+1)*CHAR_W-1 : i*CHAR_W].
REQ-008 SHALL have port guess_valid, input, 1, a guess is offered.
REQ-009 SHALL have port guess_char, input, CHAR_W, the offered letter.
REQ-010 SHALL have port guess_ready, output, 1, a guess can be accepted this cycle.
REQ-011 SHALL have port found_mask, output, WORD_LEN, bit i high when letter i has been guessed.
REQ-012 SHALL have port tries_left, output, clog2(MAX_TRIES+1), remaining wrong guesses.
REQ-013 SHALL have port win, output, 1, game won; held high until the next start or rst.
REQ-014 SHALL have port lose, output, 1, game lost; held high until the next start or rst.
REQ-015 SHALL have port last_hit, output, 1, the most recent evaluated guess matched at least one unfound letter.

Function
REQ-016 SHALL implement the states IDLE, LOAD, PLAY, CHECK, WIN and LOSE.
REQ-017 SHALL move from IDLE, WIN or LOSE to LOAD when start=1, and SHALL ignore start in LOAD, PLAY and CHECK.
REQ-018 SHALL, in LOAD, latch word, set tries_left=MAX_TRIES, clear found_mask, last_hit, win and lose, then enter PLAY on the next edge.
REQ-019 SHALL drive guess_ready=1 only in PLAY; a guess is accepted on an edge where guess_valid and guess_ready are both 1.
REQ-020 SHALL, on acceptance, latch guess_char and enter CHECK; guess_char is ignored at all other times.
REQ-021 SHALL, in CHECK, compare the latched guess against every latched letter in parallel and OR all matching positions into found_mask on the exiting edge, so updates are visible 2 edges after acceptance.
REQ-022 SHALL treat a guess as a hit when it matches at least one position not yet set in found_mask: set last_hit=1 and leave tries_left unchanged.
REQ-023 SHALL treat a guess matching only already-found positions as a repeat: no change to found_mask or tries_left, and last_hit=0.
REQ-024 SHALL treat a guess matching no position as a miss: decrement tries_left by 1 and set last_hit=0; tries_left never wraps below 0.
REQ-025 SHALL, on leaving CHECK, go to WIN if the updated found_mask is all ones, otherwise to LOSE if the updated tries_left is 0, otherwise to PLAY.
REQ-026 SHALL make win and lose mutually exclusive, with win taking precedence.
REQ-027 SHALL hold found_mask, tries_left and last_hit stable in WIN and LOSE.
REQ-028 SHALL set win=1 or lose=1 on the edge that enters WIN or LOSE respectively.

Reset
REQ-029 SHALL, while rst=1, immediately force state=IDLE, found_mask=0, tries_left=MAX_TRIES, guess_ready=0, win=0, lose=0, last_hit=0, and clear the latched word and guess.
REQ-030 SHALL abandon any game in progress, including a guess in CHECK, when rst is asserted, with no partial update surviving.
REQ-031 SHALL enter LOAD on the first edge after rst deasserts only if start=1 on that edge; otherwise it remains in IDLE.

Structure
REQ-032 SHALL place the state enumeration and the default parameter values in shared package hangman_pkg.
REQ-033 SHALL use one sub-module, hangman_match, a combinational per-position comparator returning a WORD_LEN match vector.
REQ-034 SHALL reject WORD_LEN<1, CHAR_W<1 or MAX_TRIES<1 by elaboration-time check.

Verification
REQ-035 SHALL cover loss: defaults, word=01101_01110_10011_10001_00101, 7 guesses of 00000 -> tries_left steps 6..0, lose=1 two edges after the 7th acceptance, win=0.
REQ-036 SHALL cover win: same word, guess all 5 letters -> found_mask fills one bit per guess, tries_left=7, win=1 after the 5th guess.
REQ-037 SHALL cover the mixed case: 2 misses, a repeat of a found letter, then the remaining letters -> tries_left=5, the repeat changes nothing, win=1.
REQ-038 SHALL cover duplicates: WORD_LEN=4, word=A_B_A_C, guess A -> found_mask=0101 from a single guess.
REQ-039 SHALL cover reset mid-game: assert rst during CHECK -> all outputs return to their reset values within the same cycle, and guess_ready stays 0 until a start.
REQ-040 SHALL cover start abuse: start pulsed in PLAY -> ignored; start in WIN -> LOAD, then tries_left=MAX_TRIES and found_mask=0.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman controller: state encoding and default sizing.
package hangman_pkg;

  localparam int DEF_WORD_LEN  = 5;
  localparam int DEF_CHAR_W    = 5;
  localparam int DEF_MAX_TRIES = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    CHECK,
    WIN,
    LOSE
  } state_t;

endpackage

// File: rtl/hangman_match.sv
// Per-position letter comparator: bit i of match is high when letter i equals guess.
module hangman_match
  import hangman_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int CHAR_W   = DEF_CHAR_W
) (
  input  logic [WORD_LEN*CHAR_W-1:0] word,
  input  logic [CHAR_W-1:0]          guess,
  output logic [WORD_LEN-1:0]        match
);

  // Compare every letter slot against the guess in parallel
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      match[i] = (word[i*CHAR_W +: CHAR_W] == guess);
    end
  end

endmodule

// File: rtl/hangman_ctrl_p.sv
// Hangman game controller: loads a secret word, evaluates one guess at a time,
// tracks found letters and remaining wrong guesses, and reports win/lose.
module hangman_ctrl_p
  import hangman_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WORD_LEN*CHAR_W-1:0]        word,
  input  logic                              guess_valid,
  input  logic [CHAR_W-1:0]                 guess_char,
  output logic                              guess_ready,
  output logic [WORD_LEN-1:0]               found_mask,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left,
  output logic                              win,
  output logic                              lose,
  output logic                              last_hit
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  if (WORD_LEN < 1 || CHAR_W < 1 || MAX_TRIES < 1) begin : g_bad_params
    $error("hangman_ctrl_p: WORD_LEN, CHAR_W and MAX_TRIES must all be >= 1");
  end

  state_t                      state_q, state_d;
  logic [WORD_LEN*CHAR_W-1:0]  word_q;
  logic [CHAR_W-1:0]           guess_q;
  logic [WORD_LEN-1:0]         match;
  logic [WORD_LEN-1:0]         mask_upd;
  logic [TW-1:0]               tries_upd;
  logic                        hit;

  hangman_match #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W)
  ) u_match (
    .word  (word_q),
    .guess (guess_q),
    .match (match)
  );

  // Outcome of the guess held in CHECK: merged mask, hit flag and decremented tries
  always_comb begin
    mask_upd  = found_mask | match;
    hit       = |(match & ~found_mask);
    tries_upd = tries_left;
    if (match == '0 && tries_left != '0) begin
      tries_upd = tries_left - TW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; win is tested before lose so it takes precedence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WIN, LOSE: if (start) state_d = LOAD;
      LOAD:            state_d = PLAY;
      PLAY:            if (guess_valid) state_d = CHECK;
      CHECK: begin
        if (&mask_upd)            state_d = WIN;
        else if (tries_upd == '0) state_d = LOSE;
        else                      state_d = PLAY;
      end
      default:         state_d = IDLE;
    endcase
  end

  // Handshake output: guesses are only taken while playing
  always_comb begin
    guess_ready = (state_q == PLAY);
  end

  // Game datapath: word/guess latches, progress and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      guess_q    <= '0;
      found_mask <= '0;
      tries_left <= TW'(MAX_TRIES);
      last_hit   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, WIN, LOSE: begin
          if (start) begin
            win  <= 1'b0;
            lose <= 1'b0;
          end
        end
        LOAD: begin
          word_q     <= word;
          found_mask <= '0;
          tries_left <= TW'(MAX_TRIES);
          last_hit   <= 1'b0;
          win        <= 1'b0;
          lose       <= 1'b0;
        end
        PLAY: begin
          if (guess_valid) guess_q <= guess_char;
        end
        CHECK: begin
          found_mask <= mask_upd;
          tries_left <= tries_upd;
          last_hit   <= hit;
          win        <= &mask_upd;
          lose       <= ~(&mask_upd) && (tries_upd == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hangman_ctrl_p.sv
// Directed testbench for hangman_ctrl_p (default-sized game plus a 4-letter duplicate-letter game).
module tb_hangman_ctrl_p;

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] word;
  logic        guess_valid;
  logic [4:0]  guess_char;
  logic        guess_ready;
  logic [4:0]  found_mask;
  logic [2:0]  tries_left;
  logic        win, lose, last_hit;

  logic        d_start;
  logic [19:0] d_word;
  logic        d_guess_valid;
  logic [4:0]  d_guess_char;
  logic        d_guess_ready;
  logic [3:0]  d_found_mask;
  logic [2:0]  d_tries_left;
  logic        d_win, d_lose, d_last_hit;

  int n_pass;
  int n_total;

  hangman_ctrl_p dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word        (word),
    .guess_valid (guess_valid),
    .guess_char  (guess_char),
    .guess_ready (guess_ready),
    .found_mask  (found_mask),
    .tries_left  (tries_left),
    .win         (win),
    .lose        (lose),
    .last_hit    (last_hit)
  );

  hangman_ctrl_p #(
    .WORD_LEN  (4),
    .CHAR_W    (5),
    .MAX_TRIES (7)
  ) dut_dup (
    .clk         (clk),
    .rst         (rst),
    .start       (d_start),
    .word        (d_word),
    .guess_valid (d_guess_valid),
    .guess_char  (d_guess_char),
    .guess_ready (d_guess_ready),
    .found_mask  (d_found_mask),
    .tries_left  (d_tries_left),
    .win         (d_win),
    .lose        (d_lose),
    .last_hit    (d_last_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic do_guess(input logic [4:0] c);
    guess_char  = c;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++; if (guess_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", guess_ready); else n_pass++;
    n_total++; if (found_mask !== 5'b00000) $display("FAIL reset_mask got %b want 00000", found_mask); else n_pass++;
    n_total++; if (tries_left !== 3'd7) $display("FAIL reset_tries got %0d want 7", tries_left); else n_pass++;
    n_total++; if ({win, lose, last_hit} !== 3'b000) $display("FAIL reset_flags got %b want 000", {win, lose, last_hit}); else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    n_total++; if (guess_ready !== 1'b0) $display("FAIL idle_no_start got %b want 0", guess_ready); else n_pass++;
  endtask

  task automatic test_loss();
    start_game();
    n_total++; if (guess_ready !== 1'b1) $display("FAIL loss_ready got %b want 1", guess_ready); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      do_guess(5'd0);
      n_total++; if (tries_left !== 3'(6 - i)) $display("FAIL loss_tries[%0d] got %0d want %0d", i, tries_left, 6 - i); else n_pass++;
      n_total++; if (last_hit !== 1'b0) $display("FAIL loss_hit[%0d] got %b want 0", i, last_hit); else n_pass++;
      n_total++; if (lose !== (i == 6)) $display("FAIL loss_lose[%0d] got %b want %b", i, lose, (i == 6)); else n_pass++;
    end
    n_total++; if (win !== 1'b0) $display("FAIL loss_win got %b want 0", win); else n_pass++;
    n_total++; if (found_mask !== 5'b00000) $display("FAIL loss_mask got %b want 00000", found_mask); else n_pass++;
    n_total++; if (guess_ready !== 1'b0) $display("FAIL loss_ready_after got %b want 0", guess_ready); else n_pass++;
    guess_valid = 1'b1;
    guess_char  = 5'd0;
    tick();
    tick();
    guess_valid = 1'b0;
    n_total++; if (tries_left !== 3'd0) $display("FAIL loss_hold_tries got %0d want 0", tries_left); else n_pass++;
    n_total++; if (lose !== 1'b1) $display("FAIL loss_hold_lose got %b want 1", lose); else n_pass++;
  endtask

  task automatic test_win();
    logic [4:0] letters [5];
    letters = '{5'd5, 5'd17, 5'd19, 5'd14, 5'd13};
    start_game();
    n_total++; if (lose !== 1'b0) $display("FAIL win_lose_cleared got %b want 0", lose); else n_pass++;
    guess_char  = letters[0];
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    n_total++; if (found_mask !== 5'b00000) $display("FAIL win_check_latency got %b want 00000", found_mask); else n_pass++;
    n_total++; if (guess_ready !== 1'b0) $display("FAIL win_check_ready got %b want 0", guess_ready); else n_pass++;
    tick();
    n_total++; if (found_mask !== 5'b00001) $display("FAIL win_mask[0] got %b want 00001", found_mask); else n_pass++;
    for (int k = 1; k < 5; k++) begin
      do_guess(letters[k]);
      n_total++; if (found_mask !== 5'((1 << (k + 1)) - 1)) $display("FAIL win_mask[%0d] got %b want %b", k, found_mask, 5'((1 << (k + 1)) - 1)); else n_pass++;
      n_total++; if (last_hit !== 1'b1) $display("FAIL win_hit[%0d] got %b want 1", k, last_hit); else n_pass++;
      n_total++; if (win !== (k == 4)) $display("FAIL win_win[%0d] got %b want %b", k, win, (k == 4)); else n_pass++;
    end
    n_total++; if (tries_left !== 3'd7) $display("FAIL win_tries got %0d want 7", tries_left); else n_pass++;
    n_total++; if (lose !== 1'b0) $display("FAIL win_lose got %b want 0", lose); else n_pass++;
  endtask

  task automatic test_mixed();
    start_game();
    do_guess(5'd0);
    do_guess(5'd31);
    n_total++; if (tries_left !== 3'd5) $display("FAIL mixed_two_miss got %0d want 5", tries_left); else n_pass++;
    do_guess(5'd5);
    n_total++; if ({found_mask, last_hit} !== 6'b00001_1) $display("FAIL mixed_hit got %b want 000011", {found_mask, last_hit}); else n_pass++;
    do_guess(5'd5);
    n_total++; if (found_mask !== 5'b00001) $display("FAIL mixed_repeat_mask got %b want 00001", found_mask); else n_pass++;
    n_total++; if (tries_left !== 3'd5) $display("FAIL mixed_repeat_tries got %0d want 5", tries_left); else n_pass++;
    n_total++; if (last_hit !== 1'b0) $display("FAIL mixed_repeat_hit got %b want 0", last_hit); else n_pass++;
    do_guess(5'd17);
    do_guess(5'd19);
    do_guess(5'd14);
    do_guess(5'd13);
    n_total++; if ({win, lose} !== 2'b10) $display("FAIL mixed_result got %b want 10", {win, lose}); else n_pass++;
    n_total++; if (tries_left !== 3'd5) $display("FAIL mixed_tries_end got %0d want 5", tries_left); else n_pass++;
  endtask

  task automatic test_start_abuse();
    start_game();
    n_total++; if (tries_left !== 3'd7) $display("FAIL restart_tries got %0d want 7", tries_left); else n_pass++;
    n_total++; if (found_mask !== 5'b00000) $display("FAIL restart_mask got %b want 00000", found_mask); else n_pass++;
    n_total++; if (win !== 1'b0) $display("FAIL restart_win got %b want 0", win); else n_pass++;
    do_guess(5'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (guess_ready !== 1'b1) $display("FAIL play_start_ready got %b want 1", guess_ready); else n_pass++;
    n_total++; if (found_mask !== 5'b00001) $display("FAIL play_start_mask got %b want 00001", found_mask); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_guess(5'd0);
    n_total++; if (tries_left !== 3'd6) $display("FAIL mid_pre_tries got %0d want 6", tries_left); else n_pass++;
    guess_char  = 5'd17;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_total++; if (found_mask !== 5'b00000) $display("FAIL mid_rst_mask got %b want 00000", found_mask); else n_pass++;
    n_total++; if (tries_left !== 3'd7) $display("FAIL mid_rst_tries got %0d want 7", tries_left); else n_pass++;
    n_total++; if ({guess_ready, win, lose, last_hit} !== 4'b0000) $display("FAIL mid_rst_flags got %b want 0000", {guess_ready, win, lose, last_hit}); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    n_total++; if ({guess_ready, found_mask} !== 6'b0_00000) $display("FAIL mid_after_rst got %b want 000000", {guess_ready, found_mask}); else n_pass++;
    start_game();
    n_total++; if (guess_ready !== 1'b1) $display("FAIL mid_restart_ready got %b want 1", guess_ready); else n_pass++;
  endtask

  task automatic test_duplicates();
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick();
    d_guess_char  = 5'd1;
    d_guess_valid = 1'b1;
    tick();
    d_guess_valid = 1'b0;
    tick();
    n_total++; if (d_found_mask !== 4'b0101) $display("FAIL dup_mask got %b want 0101", d_found_mask); else n_pass++;
    n_total++; if ({d_last_hit, d_tries_left} !== 4'b1_111) $display("FAIL dup_hit_tries got %b want 1111", {d_last_hit, d_tries_left}); else n_pass++;
    d_guess_char  = 5'd2;
    d_guess_valid = 1'b1;
    tick();
    d_guess_char  = 5'd3;
    tick();
    tick();
    d_guess_valid = 1'b0;
    tick();
    n_total++; if ({d_found_mask, d_win} !== 5'b1111_1) $display("FAIL dup_win got %b want 11111", {d_found_mask, d_win}); else n_pass++;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    start         = 1'b0;
    word          = 25'b01101_01110_10011_10001_00101;
    guess_valid   = 1'b0;
    guess_char    = 5'd0;
    d_start       = 1'b0;
    d_word        = {5'd3, 5'd1, 5'd2, 5'd1};
    d_guess_valid = 1'b0;
    d_guess_char  = 5'd0;

    test_reset();
    test_loss();
    test_win();
    test_mixed();
    test_start_abuse();
    test_reset_mid();
    test_duplicates();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
